// File: rtl/dma_rd_axi_bridge.sv
// dma_rd_axi_bridge
//   Turns one DMA engine read request (addr/len) into a single AXI4 INCR read burst and
//   forwards the returned R beats to the engine with no added latency. One burst may be
//   outstanding at a time. rd_last is regenerated from an internal beat counter, and a
//   sticky error flag records misaligned requests, error responses and rlast mismatches.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   req_addr_i/len_i/valid_i engine request (len is beats-1), req_ready_o accepts it
//   rd_rdata_o/last_o/valid_o beat data to the engine, rd_ready_i engine back-pressure
//   m_ar*                    AXI AR channel (INCR, size fixed by DATA_WIDTH)
//   m_r*                     AXI R channel
//   busy_o                   a burst is in progress
//   err_o, err_clr_i         sticky error flag and its clear (a new error wins over clear)
module dma_rd_axi_bridge #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  // Engine request channel
  input  logic [31:0]           req_addr_i,
  input  logic [4:0]            req_len_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  // Engine read data channel
  output logic [DATA_WIDTH-1:0] rd_rdata_o,
  output logic                  rd_last_o,
  output logic                  rd_valid_o,
  input  logic                  rd_ready_i,
  // AXI AR channel
  output logic [31:0]           m_araddr_o,
  output logic [7:0]            m_arlen_o,
  output logic [2:0]            m_arsize_o,
  output logic [1:0]            m_arburst_o,
  output logic                  m_arvalid_o,
  input  logic                  m_arready_i,
  // AXI R channel
  input  logic [DATA_WIDTH-1:0] m_rdata_i,
  input  logic [1:0]            m_rresp_i,
  input  logic                  m_rlast_i,
  input  logic                  m_rvalid_i,
  output logic                  m_rready_o,
  // Status
  output logic                  busy_o,
  output logic                  err_o,
  input  logic                  err_clr_i
);

  localparam logic [2:0] ArSize  = 3'($clog2(DATA_WIDTH / 8));
  localparam logic [1:0] BurstIncr = 2'b01;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAr   = 2'd1,
    StData = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] araddr_q, araddr_d;
  logic [4:0]  arlen_q, arlen_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        err_q, err_d;

  logic        req_hs;
  logic        r_hs;
  logic        cnt_zero;
  logic        err_set;

  assign cnt_zero = (cnt_q == 5'd0);

  always_comb begin
    state_d     = state_q;
    araddr_d    = araddr_q;
    arlen_d     = arlen_q;
    cnt_d       = cnt_q;
    req_ready_o = 1'b0;
    m_arvalid_o = 1'b0;
    rd_valid_o  = 1'b0;
    rd_last_o   = 1'b0;
    m_rready_o  = 1'b0;
    req_hs      = 1'b0;
    r_hs        = 1'b0;

    unique case (state_q)
      StIdle: begin
        req_ready_o = 1'b1;
        req_hs      = req_valid_i;
        if (req_valid_i) begin
          // Misaligned requests are still issued, rounded down to a word boundary.
          araddr_d = {req_addr_i[31:2], 2'b00};
          arlen_d  = req_len_i;
          state_d  = StAr;
        end
      end
      StAr: begin
        m_arvalid_o = 1'b1;
        if (m_arready_i) begin
          cnt_d   = arlen_q;
          state_d = StData;
        end
      end
      StData: begin
        rd_valid_o = m_rvalid_i;
        m_rready_o = rd_ready_i;
        rd_last_o  = cnt_zero;
        r_hs       = m_rvalid_i & rd_ready_i;
        if (r_hs) begin
          if (cnt_zero) begin
            state_d = StIdle;
          end else begin
            cnt_d = cnt_q - 5'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Our own count decides the end of the burst; a disagreeing m_rlast is only flagged.
  assign err_set = (req_hs && (req_addr_i[1:0] != 2'b00)) ||
                   (r_hs && ((m_rresp_i != 2'b00) || (m_rlast_i != cnt_zero)));

  always_comb begin
    err_d = err_q;
    if (err_set) begin
      err_d = 1'b1;
    end else if (err_clr_i) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      araddr_q <= 32'd0;
      arlen_q  <= 5'd0;
      cnt_q    <= 5'd0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      araddr_q <= araddr_d;
      arlen_q  <= arlen_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  assign rd_rdata_o  = m_rdata_i;
  assign m_araddr_o  = araddr_q;
  assign m_arlen_o   = {3'b000, arlen_q};
  assign m_arsize_o  = ArSize;
  assign m_arburst_o = BurstIncr;
  assign busy_o      = (state_q != StIdle);
  assign err_o       = err_q;

endmodule
